// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and multicycle FSM states.
// Used by the multicycle ALU and the ALU control decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_RSV = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub/and/or/slt, serial 1-bit/cycle shifts.
// Ports: clk, reset_n (async low), start/alu_control/operand_a/operand_b/shamt
// in; busy, done (1-cycle pulse), result, zero (registered) out.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2:0]             alu_control,
  input  logic [DATA_WIDTH-1:0]  operand_a,
  input  logic [DATA_WIDTH-1:0]  operand_b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  alu_state_e              r_state, w_state_nxt;
  alu_op_e                 r_op, w_op_nxt, w_op_in;
  logic [SHAMT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_result, w_res_nxt;
  logic                    r_zero;
  logic [DATA_WIDTH-1:0]   w_alu;
  logic                    w_slt;

  assign w_op_in = alu_op_e'(alu_control);
  assign w_slt   = $signed(operand_a) < $signed(operand_b);

  always_comb begin
    w_alu = '0;
    case (w_op_in)
      ALU_ADD: w_alu = operand_a + operand_b;
      ALU_SUB: w_alu = operand_a - operand_b;
      ALU_AND: w_alu = operand_a & operand_b;
      ALU_OR:  w_alu = operand_a | operand_b;
      ALU_SLT: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      // shifts start from operand_a; the shift itself runs in SHIFT
      ALU_SLL: w_alu = operand_a;
      ALU_SRL: w_alu = operand_a;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_result;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_op_nxt  = w_op_in;
          w_res_nxt = w_alu;
          if ((w_op_in == ALU_SLL || w_op_in == ALU_SRL) &&
              shamt != '0) begin
            w_cnt_nxt   = shamt;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (r_op == ALU_SLL)
          w_res_nxt = {r_result[DATA_WIDTH-2:0], 1'b0};
        else
          w_res_nxt = {1'b0, r_result[DATA_WIDTH-1:1]};
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_op     <= ALU_ADD;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_res_nxt;
      // tracks every result write; unchanged result keeps zero unchanged
      r_zero   <= (w_res_nxt == '0);
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: vector table, directed corner
// sequences and random ops against a behavioural model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int n_pass = 0;
  int n_total = 0;

  multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .alu_control(alu_control), .operand_a(operand_a),
    .operand_b(operand_b), .shamt(shamt), .busy(busy),
    .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      3'd7: return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op,
                                   input logic [4:0] sh);
    if (op >= 3'd6 && sh != 5'd0) return int'(sh) + 1;
    return 1;
  endfunction

  // Issue one op; scramble inputs right after acceptance; return the
  // number of cycles until done is seen and the captured outputs.
  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh,
                     output int lat, output int nbusy,
                     output logic [31:0] r, output logic z);
    @(negedge clk);
    alu_control = op; operand_a = a; operand_b = b; shamt = sh;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    alu_control = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    shamt = 5'($urandom);
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 200);
    r = result;
    z = zero;
  endtask

  task automatic check_op(input string name, input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
      input logic [31:0] er, input logic ez, input int elat);
    int lat, nb;
    logic [31:0] r;
    logic z;
    run(op, a, b, sh, lat, nb, r, z);
    chk({name, " result"}, r, er);
    chk({name, " zero"}, 32'(z), 32'(ez));
    chk({name, " latency"}, lat, elat);
    chk({name, " busy cycles"}, nb, elat);
    @(negedge clk);
    chk({name, " done pulse"}, {busy, done}, 32'd0);
    chk({name, " hold"}, result, er);
  endtask

  initial begin
    int lat, nb, dones;
    logic [31:0] r, ra, rb;
    logic [2:0] rop;
    logic [4:0] rsh;
    logic z;

    vecs[0] = '{3'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1};
    vecs[1] = '{3'd1, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1};
    vecs[2] = '{3'd4, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1};
    vecs[3] = '{3'd4, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1};
    vecs[4] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,
                32'h00F0_1200, 1'b0, 1};
    vecs[5] = '{3'd3, 32'hF000_0000, 32'h0000_000F, 5'd0,
                32'hF000_000F, 1'b0, 1};
    vecs[6] = '{3'd5, 32'h1234, 32'h5678, 5'd9, 32'd0, 1'b1, 1};
    vecs[7] = '{3'd7, 32'h000000A5, 32'd0, 5'd0, 32'h000000A5, 1'b0, 1};
    vecs[8] = '{3'd6, 32'h1, 32'd0, 5'd4, 32'h10, 1'b0, 5};
    vecs[9] = '{3'd7, 32'h80000000, 32'd0, 5'd31, 32'h1, 1'b0, 32};

    reset_n = 1'b0;
    start = 1'b0;
    alu_control = 3'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    shamt = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset busy/done", {busy, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", 32'(zero), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].sh, vecs[i].res, vecs[i].z, vecs[i].lat);

    // start pulsed every busy cycle, including in DONE
    @(negedge clk);
    alu_control = 3'd6; operand_a = 32'h1; shamt = 5'd3; start = 1'b1;
    @(posedge clk);
    dones = 0;
    r = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) begin dones++; r = result; end
      alu_control = 3'd0;
      operand_a = $urandom;
      operand_b = $urandom;
      shamt = 5'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    chk("spam idle after done", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("spam done count", dones, 32'd1);
    chk("spam result", r, 32'h8);

    // reset during SHIFT cycle 2
    @(negedge clk);
    alu_control = 3'd6; operand_a = 32'h3; shamt = 5'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort busy/done", {busy, done}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort zero", 32'(zero), 32'd1);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", dones, 32'd0);
    check_op("post-reset add", 3'd0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rsh = 5'($urandom);
      run(rop, ra, rb, rsh, lat, nb, r, z);
      chk($sformatf("rand%0d op%0d result", i, rop), r,
          model(rop, ra, rb, rsh));
      chk($sformatf("rand%0d zero", i), 32'(z),
          32'(model(rop, ra, rb, rsh) == 32'd0));
      chk($sformatf("rand%0d latency", i), lat, model_lat(rop, rsh));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_WIDTH, default 5, shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port alu_control  input  3  op code: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 reserved, 6 sll, 7 srl.
REQ-007 SHALL have port operand_a  input  DATA_WIDTH  first operand, shift source for codes 6 and 7.
REQ-008 SHALL have port operand_b  input  DATA_WIDTH  second operand.
REQ-009 SHALL have port shamt  input  SHAMT_WIDTH  shift count for codes 6 and 7.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port result  output  DATA_WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered flag, high when result equals 0.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL sample alu_control, operands and shamt only on the accepting edge; later input changes have no effect on the op in flight.
REQ-016 SHALL, from IDLE with start=1 and code in {0..5}, load result and go to DONE; done high on the next cycle (latency 1).
REQ-017 SHALL compute add/sub modulo 2^DATA_WIDTH, with no overflow indication.
REQ-018 SHALL compute slt as a signed two's-complement compare (operand_a < operand_b), giving 1 or 0 zero-extended.
REQ-019 SHALL produce result 0 for code 5.
REQ-020 SHALL, for codes 6/7 with shamt=0, load operand_a unchanged and go to DONE (latency 1).
REQ-021 SHALL, for codes 6/7 with shamt=n>0, load operand_a and counter=n, then enter SHIFT.
REQ-022 SHALL, in SHIFT, shift result one bit per cycle (sll: zero fill at LSB; srl: logical, zero fill at MSB) and decrement the counter.
REQ-023 SHALL leave SHIFT for DONE on the cycle the counter decrements to 0, so done is asserted n+1 cycles after the accepting edge.
REQ-024 SHALL assert done only in DONE, for exactly one cycle; DONE always returns to IDLE.
REQ-025 SHALL ignore start while busy, including in DONE, so the minimum issue interval is 2 cycles.
REQ-026 SHALL update zero together with every result register write.
REQ-027 SHALL hold result and zero stable from done until the next accepted start.

Reset
REQ-028 SHALL, on reset_n low (asynchronous), force state IDLE, counter 0, result 0, zero 1, busy 0, done 0.
REQ-029 SHALL abort any in-flight op on reset with no done pulse; the first start after release is accepted normally.

Structure
REQ-030 SHALL take op-code constants (ALU_ADD..ALU_SRL) and the FSM state type from shared package alu_pkg, also used by the ALU control decoder.
REQ-031 SHALL be a single module with no sub-module; op logic and shifter are inline.

Verification
REQ-032 SHALL test add: a=0x7FFFFFFF, b=1, code 0 -> done next cycle, result 0x80000000, zero 0.
REQ-033 SHALL test sub/slt: code 1, a=b=5 -> result 0, zero 1; code 4, a=0xFFFFFFFF, b=1 -> result 1.
REQ-034 SHALL test sll: a=0x1, shamt=4, code 6 -> busy 5 cycles, done at accept+5, result 0x10; srl: a=0x80000000, shamt=31 -> result 0x1, done at accept+32.
REQ-035 SHALL test shamt=0 with code 7, a=0xA5 -> done at accept+1, result 0xA5.
REQ-036 SHALL test start pulsed every cycle during an sll of shamt=3, including in DONE -> only the first op executes, one done pulse.
REQ-037 SHALL test reset_n low at SHIFT cycle 2 -> outputs at reset values immediately, no done; the next add 2+3 gives 5.
